// File: rtl/song_pkg.sv
// Shared song-chart definitions: ROM word layout, note codes and
// sequencer state encoding.
package song_pkg;

    localparam int END_BIT  = 7;
    localparam int DUR_MSB  = 6;
    localparam int DUR_LSB  = 3;
    localparam int NOTE_MSB = 2;

    localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;
    localparam int NOTE_W = NOTE_MSB + 1;

    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_1    = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_2    = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_3    = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_4    = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_5    = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_6    = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_7    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DUR_W-1:0]  dur;
        logic [NOTE_W-1:0] note;
    } rom_word_t;

    // A zero duration still plays for one beat.
    function automatic logic [DUR_W-1:0] beats_of(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat tick counter with clear/enable gating; emits a registered
// one-cycle beat pulse after each completed beat.
module beat_timer #(
    parameter int BEAT_TICKS = 1_687_500
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wrap,
    output logic beat_pulse
);

    localparam int TW = (BEAT_TICKS > 2) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [TW-1:0] LAST = TW'(BEAT_TICKS - 1);

    logic [TW-1:0] tick;

    assign wrap = enable && !clear && (tick == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick       <= '0;
            beat_pulse <= 1'b0;
        end else begin
            beat_pulse <= wrap;
            if (clear) begin
                tick <= '0;
            end else if (enable) begin
                tick <= wrap ? '0 : tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song-chart player: fetches notes from the song ROM, holds each for
// its beat count and tallies hit/miss judgements from scoreUpdater.
module note_sequencer
    import song_pkg::*;
#(
    parameter int BEAT_TICKS = 1_687_500,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [2:0]        current_note,
    output logic              beat_pulse,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    rom_word_t        word;
    logic [DUR_W-1:0] beats_left;
    logic             hit_seen;
    logic             wrap;
    logic             tmr_clear;
    logic             tmr_enable;

    assign word       = rom_data;
    assign tmr_clear  = (state == ST_LOAD);
    assign tmr_enable = (state == ST_PLAY) && !pause;

    assign busy = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_PLAY);
    assign done = (state == ST_DONE);

    beat_timer #(
        .BEAT_TICKS(BEAT_TICKS)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmr_clear),
        .enable    (tmr_enable),
        .wrap      (wrap),
        .beat_pulse(beat_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rom_addr     <= '0;
            current_note <= NOTE_REST;
            beats_left   <= '0;
            hit_seen     <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_addr   <= '0;
                        hit_count  <= '0;
                        miss_count <= '0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    hit_seen <= 1'b0;
                    if (word.last) begin
                        current_note <= NOTE_REST;
                        state        <= ST_DONE;
                    end else begin
                        current_note <= word.note;
                        beats_left   <= beats_of(word.dur);
                        state        <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (hit) begin
                        hit_seen <= 1'b1;
                    end
                    if (wrap) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == DUR_W'(1)) begin
                            // Rests are never judged.
                            if (current_note != NOTE_REST) begin
                                if (hit_seen || hit) begin
                                    if (hit_count != CNT_MAX)
                                        hit_count <= hit_count + 1'b1;
                                end else begin
                                    if (miss_count != CNT_MAX)
                                        miss_count <= miss_count + 1'b1;
                                end
                            end
                            current_note <= NOTE_REST;
                            if (rom_addr == ADDR_MAX) begin
                                state <= ST_DONE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: note run-lengths and end-of-song
// results are queued by stimulus and checked by an independent monitor.
module tb_note_sequencer;

    localparam int BT = 4;
    localparam int AW = 2;
    localparam int CW = 2;
    localparam logic [7:0] END_W = 8'h80;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pause;
    logic          hit;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [2:0]    current_note;
    logic          beat_pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    logic [7:0] rom [4];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    note_sequencer #(
        .BEAT_TICKS(BT),
        .ADDR_W    (AW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .hit         (hit),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .current_note(current_note),
        .beat_pulse  (beat_pulse),
        .busy        (busy),
        .done        (done),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // kind 0 = run (note, cycles), 1 = result (hits, misses),
    // 2 = beat pulses, 3 = final rom_addr
    typedef struct {
        int kind;
        int a;
        int b;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int   cur_note = 0;
    int   cur_len  = 0;
    int   pulses   = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    function automatic string kname(input int k);
        case (k)
            0:       return "run";
            1:       return "result";
            2:       return "pulses";
            default: return "end_addr";
        endcase
    endfunction

    function automatic logic [7:0] w(input int note, input int dur);
        logic [3:0] d;
        logic [2:0] n;
        d = dur[3:0];
        n = note[2:0];
        return {1'b0, d, n};
    endfunction

    task automatic push(input int kind, input int a, input int b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int kind, input int a, input int b);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got %0d,%0d with nothing expected",
                     kname(kind), a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                miscompares++;
                $display("FAIL %s: got %0d,%0d expected %s %0d,%0d",
                         kname(kind), a, b, kname(e.kind), e.a, e.b);
            end
        end
    endtask

    // Monitor: compresses current_note into runs while busy and reports
    // counters, pulse count and address when done rises.
    initial begin
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) pulses = 0;
            if (beat_pulse) pulses++;
            if (busy) begin
                if (cur_len > 0 && int'(current_note) != cur_note) begin
                    observe(0, cur_note, cur_len);
                    cur_len = 0;
                end
                cur_note = int'(current_note);
                cur_len++;
            end else if (cur_len > 0) begin
                observe(0, cur_note, cur_len);
                cur_len = 0;
            end
            if (done && !prev_done) begin
                observe(1, int'(hit_count), int'(miss_count));
                observe(2, pulses, 0);
                observe(3, int'(rom_addr), 0);
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_note(input int val, input int limit);
        int n = 0;
        while (!(busy && int'(current_note) == val) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_note: got no note %0d expected within %0d", val, limit);
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_done: got done=0 expected 1 within %0d", limit);
        end
    endtask

    task automatic set_rom(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
        rom[3] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        hit   = 1'b0;
        set_rom(END_W, END_W, END_W, END_W);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_note", current_note, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_pulse", beat_pulse, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single held note, hit held high
        set_rom(w(1, 2), END_W, 8'h00, 8'h00);
        hit = 1'b1;
        push(0, 0, 2); push(0, 1, 8); push(0, 0, 2);
        push(1, 1, 0); push(2, 2, 0); push(3, 1, 0);
        do_start();
        wait_done(100);
        hit = 1'b0;

        // rest is not judged; start during PLAY ignored
        set_rom(w(3, 1), w(0, 1), w(5, 1), END_W);
        push(0, 0, 2); push(0, 3, 4); push(0, 0, 8);
        push(0, 5, 4); push(0, 0, 2);
        push(1, 0, 2); push(2, 3, 0); push(3, 3, 0);
        do_start();
        wait_note(3, 20);
        do_start();
        wait_done(100);

        // sticky hit within a note; hit during FETCH not carried over
        set_rom(w(2, 3), w(4, 1), END_W, 8'h00);
        push(0, 0, 2); push(0, 2, 12); push(0, 0, 2);
        push(0, 4, 4); push(0, 0, 2);
        push(1, 1, 1); push(2, 4, 0); push(3, 2, 0);
        do_start();
        wait_note(2, 20);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        wait_note(0, 40);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        wait_done(100);

        // pause for 10 cycles mid-note
        set_rom(w(6, 2), END_W, 8'h00, 8'h00);
        push(0, 0, 2); push(0, 6, 18); push(0, 0, 2);
        push(1, 0, 1); push(2, 2, 0); push(3, 1, 0);
        do_start();
        wait_note(6, 20);
        @(negedge clk);
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("pause_pulse", beat_pulse, 0);
            chk("pause_note", current_note, 6);
        end
        pause = 1'b0;
        wait_done(100);

        // dur=0 plays one beat; no end word, stops at top address; saturation
        set_rom(w(1, 0), w(2, 1), w(3, 0), w(4, 1));
        push(0, 0, 2); push(0, 1, 4); push(0, 0, 2); push(0, 2, 4);
        push(0, 0, 2); push(0, 3, 4); push(0, 0, 2); push(0, 4, 4);
        push(1, 0, 3); push(2, 4, 0); push(3, 3, 0);
        do_start();
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("top_addr_hold", rom_addr, 3);
        chk("top_done_hold", done, 1);
        chk("top_busy", busy, 0);

        // asynchronous reset mid-PLAY
        set_rom(w(1, 1), w(7, 3), END_W, 8'h00);
        hit = 1'b1;
        push(0, 0, 2); push(0, 1, 4); push(0, 0, 2); push(0, 7, 3);
        do_start();
        wait_note(7, 40);
        repeat (2) @(negedge clk);
        chk("hit_before_reset", hit_count, 1);
        chk("addr_before_reset", rom_addr, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_note", current_note, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_addr", rom_addr, 0);
        chk("async_hits", hit_count, 0);
        chk("async_miss", miss_count, 0);
        chk("async_pulse", beat_pulse, 0);
        hit = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_note", current_note, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Song-chart player that drives the expected-note stream (`current_note`) into scoreUpdater. It reads a note chart from an external synchronous song ROM and holds each note for its programmed number of beats. It consumes scoreUpdater's `hit` feedback to tally per-note hits and misses. It sits between the song ROM and scoreUpdater, and its beat pulse also feeds the display.

Parameters:
BEAT_TICKS, 1_687_500, clk cycles per beat (16 beats/s at 27 MHz); must be >= 2
ADDR_W, 8, song ROM address width
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin the song from address 0
pause  in  1  level; freezes beat timing while high
hit  in  1  from scoreUpdater; played note matches current_note
rom_addr  out  ADDR_W  song ROM address
rom_data  in  8  ROM word, valid one cycle after rom_addr; fields {end[7], dur[6:3], note[2:0]}
current_note  out  3  expected note to scoreUpdater; 0 = rest/none
beat_pulse  out  1  one-cycle pulse at each beat boundary
busy  out  1  high in FETCH, LOAD and PLAY
done  out  1  high in DONE
hit_count  out  CNT_W  notes judged hit
miss_count  out  CNT_W  notes judged missed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rom_addr=0, current_note=0, beat_pulse=0, busy=0, done=0, hit_count=0, miss_count=0; internal tick/beat counters and hit_seen cleared. Reset mid-song aborts immediately; no partial judgement is recorded.
- FSM states: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE/DONE + start: rom_addr<=0, hit/miss counters<=0, go to FETCH. In DONE, done stays high until that start. start is ignored in FETCH/LOAD/PLAY.
- FETCH: rom_addr is stable; go to LOAD next cycle (1-cycle ROM latency).
- LOAD: sample rom_data.
  - end=1 -> DONE; current_note=0.
  - Otherwise current_note<=note, beats_left<=(dur==0 ? 1 : dur), tick<=0, hit_seen<=0, go to PLAY.
- FETCH→LOAD→PLAY costs exactly 2 cycles between notes; current_note=0 during FETCH and LOAD.
- PLAY, pause=0: tick increments.
  - At tick==BEAT_TICKS-1: tick<=0, beat_pulse=1 for that cycle, beats_left decrements.
  - When beats_left goes 1->0, judge the note:
    - note!=0 and (hit_seen or hit this cycle) -> hit_count+1
    - note!=0 otherwise -> miss_count+1
    - note==0 (rest) -> neither counter changes
  - Then, if rom_addr==2^ADDR_W-1 -> DONE (no wrap); else rom_addr+1, go to FETCH.
- PLAY, pause=1: tick, beats_left and rom_addr hold; beat_pulse=0; current_note held. hit is still sampled into hit_seen.
- hit_seen is set by hit=1 in any PLAY cycle and cleared only in LOAD. hit outside PLAY is ignored.
- Counters saturate at 2^CNT_W-1.
- Outputs are registered; current_note changes only on the LOAD→PLAY and PLAY→FETCH edges.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package `song_pkg`:
  - ROM word field positions (END_BIT=7, DUR_MSB=6, DUR_LSB=3, NOTE_MSB=2)
  - note encoding constants (NOTE_REST=0 .. 7), shared with scoreUpdater
  - state enum
- One natural sub-module: `beat_timer`. It contains the tick counter, pause gating and beat_pulse generation, takes clear/enable inputs, and is reusable by the metronome display.

Test Plan:
1. BEAT_TICKS=4; ROM {note1,dur2},{end}; start, hit held high throughout -> current_note=1 for exactly 8 PLAY cycles, 2 beat_pulses, then done=1, hit_count=1, miss_count=0.
2. ROM {note3,dur1},{note0,dur1},{note5,dur1},{end}; hit never asserted -> miss_count=2, hit_count=0 (the rest is not judged); current_note sequence 3,0,0,0,5,0 with 2-cycle 0 gaps between notes.
3. {note2,dur3}; hit pulsed for one cycle during the first beat only -> hit_count=1 (sticky hit_seen); a hit pulse during FETCH of the next note -> not counted.
4. pause raised for 10 cycles mid-note -> beat_pulse absent, current_note unchanged; the note lasts BEAT_TICKS*dur + 10 cycles total.
5. Drive reset low mid-PLAY, asynchronously between clock edges -> all outputs zero immediately; after release, idle with done=0 until start.
6. ROM with dur=0 entry -> treated as 1 beat. Chart with no end word and ADDR_W=2 -> DONE after address 3, rom_addr stays 3.
